bch_ser_enc: RTL

BCH_SER_ENC -- requirements
Module: bch_ser_enc

---
 rtl/bch_ser_enc.sv | 227 ++++++++++++++++++++++
 1 files changed

// File: rtl/bch_ser_enc.sv
// Serial systematic BCH encoder: one message bit per cycle through an R-bit LFSR,
// with an optional overall-parity extension bit on the codeword.

package bch_pkg;

    function automatic int get_field_order(input int data_width, input int error_num);
        int m;
        m = 16;
        for (int i = 15; i >= 3; i--) begin
            if ((1 << i) - 1 >= data_width + i * error_num) m = i;
        end
        return m;
    endfunction

    function automatic logic [16:0] get_prim_poly(input int m);
        logic [16:0] p;
        case (m)
            3:       p = 17'h0000B;
            4:       p = 17'h00013;
            5:       p = 17'h00025;
            6:       p = 17'h00043;
            7:       p = 17'h00089;
            8:       p = 17'h0011D;
            9:       p = 17'h00211;
            10:      p = 17'h00409;
            11:      p = 17'h00805;
            12:      p = 17'h01053;
            13:      p = 17'h0201B;
            14:      p = 17'h04443;
            15:      p = 17'h08003;
            default: p = 17'h1100B;
        endcase
        return p;
    endfunction

    function automatic logic [15:0] gf_mul(input logic [15:0] a, input logic [15:0] b,
                                           input int m, input logic [16:0] prim);
        logic [16:0] acc;
        logic [16:0] x;
        acc = '0;
        x   = {1'b0, a};
        for (int i = 0; i < 16; i++) begin
            if (i < m && b[i]) acc = acc ^ x;
            x = x << 1;
            if (x[m]) x = x ^ prim;
        end
        return acc[15:0];
    endfunction

    function automatic logic [15:0] gf_alpha_pow(input int e, input int m, input logic [16:0] prim);
        logic [16:0] v;
        v = 17'd1;
        for (int i = 0; i < e; i++) begin
            v = v << 1;
            if (v[m]) v = v ^ prim;
        end
        return v[15:0];
    endfunction

    // g(x) = product of the minimal polynomials of alpha^1 .. alpha^(2t-1), one per
    // cyclotomic coset (even powers share cosets with odd ones).
    function automatic logic [63:0] get_gen_poly(input int data_width, input int error_num);
        int             m;
        int             n;
        int             e;
        int             deg;
        bit             leader;
        bit             done;
        logic [16:0]    prim;
        logic [15:0]    root;
        logic [15:0]    lower;
        logic [16*17-1:0] mp;
        logic [63:0]    g;
        logic [63:0]    prod;
        m    = get_field_order(data_width, error_num);
        prim = get_prim_poly(m);
        n    = (1 << m) - 1;
        g    = 64'd1;
        for (int i = 1; i < 2 * error_num; i += 2) begin
            leader = 1'b1;
            e      = (2 * i) % n;
            while (e != i) begin
                if (e < i) leader = 1'b0;
                e = (2 * e) % n;
            end
            if (leader) begin
                mp        = '0;
                mp[15:0]  = 16'd1;
                deg       = 0;
                e         = i;
                done      = 1'b0;
                while (!done) begin
                    root = gf_alpha_pow(e, m, prim);
                    for (int j = 16; j >= 0; j--) begin
                        lower = (j > 0) ? mp[(j-1)*16 +: 16] : 16'd0;
                        mp[j*16 +: 16] = lower ^ gf_mul(mp[j*16 +: 16], root, m, prim);
                    end
                    deg = deg + 1;
                    e   = (2 * e) % n;
                    if (e == i) done = 1'b1;
                end
                prod = '0;
                for (int j = 0; j <= deg; j++) begin
                    if (mp[j*16]) prod = prod ^ (g << j);
                end
                g = prod;
            end
        end
        return g;
    endfunction

    function automatic int poly_degree(input logic [63:0] p);
        int d;
        d = 0;
        for (int i = 0; i < 64; i++) begin
            if (p[i]) d = i;
        end
        return d;
    endfunction

    function automatic int get_code_width(input int data_width, input int error_num, input int extend_on);
        return data_width + poly_degree(get_gen_poly(data_width, error_num)) + extend_on;
    endfunction

endpackage

module bch_ser_enc #(
    parameter int pDataWidth = 16,
    parameter int pErrorNum  = 1,
    parameter int pExtendOn  = 1,
    parameter int pCodeWidth = bch_pkg::get_code_width(pDataWidth, pErrorNum, pExtendOn)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_enable,
    input  logic                  i_data_valid,
    output logic                  o_data_ready,
    input  logic [pDataWidth-1:0] i_data,
    output logic                  o_code_valid,
    input  logic                  i_code_ready,
    output logic [pCodeWidth-1:0] o_code,
    output logic                  o_busy
);

    localparam int              R        = pCodeWidth - pDataWidth - pExtendOn;
    localparam logic [63:0]     GEN_POLY = bch_pkg::get_gen_poly(pDataWidth, pErrorNum);
    localparam logic [R-1:0]    GEN_TAPS = GEN_POLY[R-1:0];
    localparam int              CNT_W    = (pDataWidth > 1) ? $clog2(pDataWidth) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(pDataWidth - 1);

    typedef enum logic [1:0] {IDLE, SHIFT, OUT} state_t;

    state_t                 state;
    logic [pDataWidth-1:0]  data_reg;
    logic [R-1:0]           lfsr;
    logic [CNT_W-1:0]       cnt;
    logic                   code_valid;
    logic                   busy;
    logic                   fb;
    logic [R-1:0]           lfsr_next;

    // Acceptance is only possible in IDLE and never while reset is held.
    assign o_data_ready = (state == IDLE) && i_enable && !rst;

    // Message enters MSB first; each bit divides the running remainder by g(x).
    assign fb        = data_reg[cnt] ^ lfsr[R-1];
    assign lfsr_next = (lfsr << 1) ^ (GEN_TAPS & {R{fb}});

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop samples
        // pre-edge values regardless of statement order.
        if (rst) begin
            state      <= IDLE;
            // NOTE: the data register is cleared too, since it drives o_code directly
            // and the codeword must read zero out of reset.
            data_reg   <= '0;
            lfsr       <= '0;
            cnt        <= '0;
            code_valid <= 1'b0;
            busy       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (i_data_valid && o_data_ready) begin
                        data_reg <= i_data;
                        lfsr     <= '0;
                        cnt      <= CNT_LOAD;
                        busy     <= 1'b1;
                        state    <= SHIFT;
                    end
                end
                SHIFT: begin
                    lfsr <= lfsr_next;
                    cnt  <= cnt - 1'b1;
                    if (cnt == '0) begin
                        code_valid <= 1'b1;
                        state      <= OUT;
                    end
                end
                OUT: begin
                    if (i_code_ready) begin
                        code_valid <= 1'b0;
                        busy       <= 1'b0;
                        state      <= IDLE;
                    end
                end
                default: begin
                    code_valid <= 1'b0;
                    busy       <= 1'b0;
                    state      <= IDLE;
                end
            endcase
        end
    end

    assign o_code_valid = code_valid;
    assign o_busy       = busy;

    generate
        if (pExtendOn != 0) begin : g_ext
            assign o_code = {^{data_reg, lfsr}, data_reg, lfsr};
        end else begin : g_no_ext
            assign o_code = {data_reg, lfsr};
        end
    endgenerate

endmodule
